// File: rtl/q_8_22_pkg.sv
// Shared types and widths for the q_8_22 operand issue stage.
package q_8_22_pkg;

  localparam int unsigned dp_width     = 5;
  localparam int unsigned iss_st_width = 3;

  typedef enum logic [iss_st_width-1:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } iss_state_t;

endpackage

// File: rtl/q_8_22_issue_if.sv
// Bundles the upstream, multiplier-side and downstream signals of the issue stage.
interface q_8_22_issue_if
  import q_8_22_pkg::*;
#(
  parameter int unsigned DP_WIDTH = dp_width
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [DP_WIDTH-1:0]     in_multiplicand;
  logic [DP_WIDTH-1:0]     in_multiplier;
  logic                    mult_start;
  logic [DP_WIDTH-1:0]     mult_multiplicand;
  logic [DP_WIDTH-1:0]     mult_multiplier;
  logic                    mult_rdy;
  logic [2*DP_WIDTH-1:0]   mult_product;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DP_WIDTH-1:0]   out_product;
  logic                    err;

  // Issue stage view.
  modport slave (
    input  in_valid, in_multiplicand, in_multiplier, mult_rdy, mult_product, out_ready,
    output in_ready, mult_start, mult_multiplicand, mult_multiplier, out_valid, out_product, err
  );

  // Environment view: producer, multiplier and consumer.
  modport master (
    output in_valid, in_multiplicand, in_multiplier, mult_rdy, mult_product, out_ready,
    input  in_ready, mult_start, mult_multiplicand, mult_multiplier, out_valid, out_product, err
  );

endinterface

// File: rtl/q_8_22_fifo.sv
// Operand FIFO; an extra pointer bit distinguishes full from empty.
module q_8_22_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_c,
  output logic              full_c,
  output logic              empty_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_c;
  assign do_pop  = pop_i && !empty_c;

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/q_8_22_issue.sv
// Streams operand pairs into the start/rdy multiplier and captures products for a consumer.
module q_8_22_issue
  import q_8_22_pkg::*;
#(
  parameter int unsigned DP_WIDTH   = dp_width,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUSY_TMO   = 4
) (
  input  logic           clk,
  input  logic           rst,
  q_8_22_issue_if.slave  bus
);

  localparam int unsigned PW = 2 * DP_WIDTH;
  localparam int unsigned CW = $clog2(BUSY_TMO + 1);

  iss_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mult_start_q;
  logic [DP_WIDTH-1:0] a_q, b_q;
  logic                out_valid_q;
  logic [PW-1:0]       out_product_q;
  logic                err_q;

  logic                fifo_full_c, fifo_empty_c;
  logic [PW-1:0]       fifo_rdata_c;
  logic                pop_c, load_ops_c, capture_c, set_err_c;

  q_8_22_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .wdata_i ({bus.in_multiplicand, bus.in_multiplier}),
    .pop_i   (pop_c),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign bus.in_ready          = !fifo_full_c;
  assign bus.mult_start        = mult_start_q;
  assign bus.mult_multiplicand = a_q;
  assign bus.mult_multiplier   = b_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_product       = out_product_q;
  assign bus.err               = err_q;

  // Next-state logic: issue, wait for busy (with retry), wait for done, hand off result.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop_c      = 1'b0;
    load_ops_c = 1'b0;
    capture_c  = 1'b0;
    set_err_c  = 1'b0;
    case (state_q)
      IDLE: begin
        // Waiting on mult_rdy also covers a multiplication left running across reset.
        if (!fifo_empty_c && bus.mult_rdy) begin
          state_d    = ISSUE;
          pop_c      = 1'b1;
          load_ops_c = 1'b1;
          cnt_d      = '0;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.mult_rdy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q + CW'(1) == CW'(BUSY_TMO)) begin
          set_err_c = 1'b1;
          cnt_d     = '0;
          state_d   = ISSUE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.mult_rdy) state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q || bus.out_ready) begin
          capture_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, result and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mult_start_q  <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mult_start_q <= (state_d == ISSUE);
      if (load_ops_c) begin
        a_q <= fifo_rdata_c[PW-1:DP_WIDTH];
        b_q <= fifo_rdata_c[DP_WIDTH-1:0];
      end
      if (capture_c) begin
        out_valid_q   <= 1'b1;
        out_product_q <= bus.mult_product;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (set_err_c) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_q_8_22_issue.sv
// Bench for q_8_22_issue with a behavioural start/rdy multiplier and a product scoreboard.
module tb_q_8_22_issue;

  logic clk;
  logic rst;

  q_8_22_issue_if #(.DP_WIDTH(5)) bus ();

  q_8_22_issue #(.DP_WIDTH(5), .FIFO_DEPTH(4), .BUSY_TMO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Multiplier stub: not reset by rst; garbage product while busy.
  logic       stub_rdy   = 1'b1;
  logic [9:0] stub_prod  = 10'd0;
  logic [4:0] stub_a     = 5'd0;
  logic [4:0] stub_b     = 5'd0;
  int         stub_cnt   = 0;
  int         stub_lat   = 2;
  logic       stub_stuck = 1'b0;

  assign bus.mult_rdy     = stub_rdy;
  assign bus.mult_product = stub_prod;

  always @(posedge clk) begin
    if (stub_cnt != 0) begin
      if (stub_cnt == 1) begin
        stub_rdy  <= 1'b1;
        stub_prod <= 10'(stub_a) * 10'(stub_b);
      end
      stub_cnt <= stub_cnt - 1;
    end else if (bus.mult_start && !stub_stuck) begin
      stub_rdy  <= 1'b0;
      stub_prod <= 10'h2AA;
      stub_cnt  <= stub_lat;
      stub_a    <= bus.mult_multiplicand;
      stub_b    <= bus.mult_multiplier;
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  int exp_q[$];
  int in_cnt = 0, out_cnt = 0, start_cnt = 0, start_viol = 0, last_out = -1, timeouts = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.mult_start) start_cnt++;
      if (bus.mult_start && !bus.mult_rdy) start_viol++;
      if (bus.out_valid && bus.out_ready) begin
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("out_product", int'(bus.out_product), e);
        last_out = int'(bus.out_product);
        out_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(int'(bus.in_multiplicand) * int'(bus.in_multiplier));
        in_cnt++;
      end
    end
  end

  // Offer one pair and hold it until accepted; entered and left just after a rising edge.
  task automatic send(input logic [4:0] a, input logic [4:0] b);
    int n = 0;
    bus.in_valid        = 1'b1;
    bus.in_multiplicand = a;
    bus.in_multiplier   = b;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeouts++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   int'(bus.in_ready), 1);
    check({tag, "_start"},      int'(bus.mult_start), 0);
    check({tag, "_mcand"},      int'(bus.mult_multiplicand), 0);
    check({tag, "_mplier"},     int'(bus.mult_multiplier), 0);
    check({tag, "_out_valid"},  int'(bus.out_valid), 0);
    check({tag, "_out_prod"},   int'(bus.out_product), 0);
    check({tag, "_err"},        int'(bus.err), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int base_in, base_out, base_start, t_start, t_err, start_at_err;
    rst                 = 1'b1;
    bus.in_valid        = 1'b0;
    bus.in_multiplicand = '0;
    bus.in_multiplier   = '0;
    bus.out_ready       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single job.
    base_start = start_cnt;
    send(5'd23, 5'd19);
    drain("single_drain");
    check("single_prod", last_out, 437);
    check("single_starts", start_cnt - base_start, 1);
    check("single_err", int'(bus.err), 0);

    // Corner operands.
    send(5'd31, 5'd31);
    send(5'd0, 5'd17);
    send(5'd1, 5'd30);
    drain("corner_drain");
    check("corner_last", last_out, 30);

    // Exhaustive stream.
    base_out = out_cnt;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        send(5'(a), 5'(b));
    drain("exh_drain");
    check("exh_count", out_cnt - base_out, 1024);

    // Back-pressure: 4 in FIFO + 1 in DONE + 1 in result register.
    bus.out_ready = 1'b0;
    base_in  = in_cnt;
    base_out = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(5'(i + 3), 5'(2 * i + 1));
      end
      begin
        repeat (60) @(negedge clk);
        check("bp_accepted", in_cnt - base_in, 6);
        check("bp_in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_out_count", out_cnt - base_out, 8);

    // Stuck multiplier: rdy never falls.
    stub_stuck   = 1'b1;
    base_start   = start_cnt;
    t_start      = -1;
    t_err        = -1;
    start_at_err = 0;
    send(5'd13, 5'd7);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mult_start && t_start < 0) t_start = i;
      if (bus.err && t_err < 0) begin
        t_err        = i;
        start_at_err = int'(bus.mult_start);
      end
    end
    check("stuck_err_delay", t_err - t_start, 5);
    check("stuck_repulse", start_at_err, 1);
    check("stuck_multi_start", int'(start_cnt - base_start > 2), 1);
    @(posedge clk); #1;
    stub_stuck = 1'b0;
    drain("stuck_drain");
    check("stuck_prod", last_out, 91);
    check("stuck_err_sticky", int'(bus.err), 1);

    // Reset in the middle of a long multiplication.
    stub_lat = 8;
    send(5'd9, 5'd9);
    for (int i = 0; i < 50 && stub_rdy; i++) @(negedge clk);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("midrst");
    check("midrst_mult_busy", int'(bus.mult_rdy), 0);
    send(5'd6, 5'd7);
    drain("midrst_drain");
    check("midrst_prod", last_out, 42);
    stub_lat = 2;

    check("start_while_busy", start_viol, 0);
    check("send_timeouts", timeouts, 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
